// File: rtl/layer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : layer_pkg
// Description : Shared types, constants and helpers for the layer write
//               scheduler (layer_dispatch and its dispatch_cnt counter).
//               Contents:
//                 dispatch_state_t - scheduler state encoding
//                 LAYER_ADDR_W     - RAM word address width (LED index)
//                 lane_onehot()    - byte index -> one-hot byte lane
// Revision    : 1.0 - initial release
// ============================================================================
package layer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } dispatch_state_t;

   localparam int LAYER_ADDR_W = 6;

   // The first byte of an LED lands in the highest used lane, so the lane
   // index counts down from bytes_per_led-1 as byte_idx counts up.
   function automatic logic [3:0] lane_onehot(input logic [1:0] byte_idx,
                                              input int         bytes_per_led);
      logic [2:0] sh;
      sh = 3'(bytes_per_led - 1) - {1'b0, byte_idx};
      return 4'b0001 << sh;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_cnt.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_cnt
// Description : Cascaded byte / LED / layer position counter for one frame.
//               Counts are presented already adjusted for clr_in, so a byte
//               arriving together with a clear is seen as position 0/0/0.
// Ports       : clk_in, rst_in      clock, async active-high reset
//               inc_in              a byte is accepted this cycle
//               clr_in              restart the frame position
//               byte_cnt_out        byte within LED   (0..BYTES_PER_LED-1)
//               led_cnt_out         LED within layer  (0..LED_NUM-1)
//               layer_cnt_out       layer             (0..LAYER_NUM-1)
//               last_out            current position is the final frame byte
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_cnt
   import layer_pkg::*;
#(
   parameter int LAYER_NUM     = 8,
   parameter int LED_NUM       = 64,
   parameter int BYTES_PER_LED = 3
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    inc_in,
   input  logic                    clr_in,
   output logic [1:0]              byte_cnt_out,
   output logic [LAYER_ADDR_W-1:0] led_cnt_out,
   output logic [3:0]              layer_cnt_out,
   output logic                    last_out
);

   localparam logic [1:0]              BYTE_MAX  = 2'(BYTES_PER_LED - 1);
   localparam logic [LAYER_ADDR_W-1:0] LED_MAX   = LAYER_ADDR_W'(LED_NUM - 1);
   localparam logic [3:0]              LAYER_MAX = 4'(LAYER_NUM - 1);

   logic [1:0]              byte_q,  byte_d;
   logic [LAYER_ADDR_W-1:0] led_q,   led_d;
   logic [3:0]              layer_q, layer_d;
   logic                    byte_last, led_last, layer_last;

   always_comb begin
      byte_cnt_out  = clr_in ? 2'd0 : byte_q;
      led_cnt_out   = clr_in ? '0   : led_q;
      layer_cnt_out = clr_in ? 4'd0 : layer_q;

      byte_last  = (byte_cnt_out  == BYTE_MAX);
      led_last   = (led_cnt_out   == LED_MAX);
      layer_last = (layer_cnt_out == LAYER_MAX);
      last_out   = byte_last && led_last && layer_last;

      byte_d  = byte_cnt_out;
      led_d   = led_cnt_out;
      layer_d = layer_cnt_out;

      if (inc_in) begin
         if (byte_last) begin
            byte_d = 2'd0;
            if (led_last) begin
               led_d = '0;
               // Only reachable on the final byte; returning to 0 leaves the
               // counter parked at the start of the next frame.
               layer_d = layer_last ? 4'd0 : layer_cnt_out + 4'd1;
            end else begin
               led_d = led_cnt_out + 1'b1;
            end
         end else begin
            byte_d = byte_cnt_out + 2'd1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         byte_q  <= 2'd0;
         led_q   <= '0;
         layer_q <= 4'd0;
      end else begin
         byte_q  <= byte_d;
         led_q   <= led_d;
         layer_q <= layer_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/layer_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : layer_dispatch
// Description : Frame-level write scheduler. Demultiplexes a pixel byte
//               stream (byte-fastest, then LED, then layer) into registered
//               per-layer RAM write strobes and pulses wr_done to every
//               layer once the full frame has been written.
// Ports       : clk_in, rst_in      clock, async active-high reset
//               frame_start_in      start (or restart) of a frame
//               data_vld_in/data_in pixel byte stream
//               wr_en_out           one-hot layer write strobe
//               wr_addr_out         word address (LED index)
//               wr_data_out         byte to write
//               wr_byte_en_out      one-hot byte lane
//               wr_done_out         frame-complete pulse to all layers
//               busy_out            receiving a frame
//               drop_out            sticky: byte seen while not receiving
// Revision    : 1.0 - initial release
// ============================================================================
module layer_dispatch
   import layer_pkg::*;
#(
   parameter int LAYER_NUM     = 8,
   parameter int LED_NUM       = 64,
   parameter int BYTES_PER_LED = 3
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    frame_start_in,
   input  logic                    data_vld_in,
   input  logic [7:0]              data_in,
   output logic [LAYER_NUM-1:0]    wr_en_out,
   output logic [LAYER_ADDR_W-1:0] wr_addr_out,
   output logic [7:0]              wr_data_out,
   output logic [3:0]              wr_byte_en_out,
   output logic [LAYER_NUM-1:0]    wr_done_out,
   output logic                    busy_out,
   output logic                    drop_out
);

   dispatch_state_t state_q, state_d;

   logic [1:0]              byte_cnt;
   logic [LAYER_ADDR_W-1:0] led_cnt;
   logic [3:0]              layer_cnt;
   logic                    last_byte;
   logic                    accept;

   logic [LAYER_NUM-1:0]    wr_en_q,      wr_en_d;
   logic [LAYER_ADDR_W-1:0] wr_addr_q,    wr_addr_d;
   logic [7:0]              wr_data_q,    wr_data_d;
   logic [3:0]              wr_byte_en_q, wr_byte_en_d;
   logic [LAYER_NUM-1:0]    wr_done_q,    wr_done_d;
   logic                    busy_q,       busy_d;
   logic                    drop_q,       drop_d;

   // A frame start opens the frame in the same cycle, so a byte that comes
   // with it is taken as the first byte of the new frame in any state.
   assign accept = data_vld_in && ((state_q == RECV) || frame_start_in);

   dispatch_cnt #(
      .LAYER_NUM     (LAYER_NUM),
      .LED_NUM       (LED_NUM),
      .BYTES_PER_LED (BYTES_PER_LED)
   ) u_cnt (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .inc_in        (accept),
      .clr_in        (frame_start_in),
      .byte_cnt_out  (byte_cnt),
      .led_cnt_out   (led_cnt),
      .layer_cnt_out (layer_cnt),
      .last_out      (last_byte)
   );

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (frame_start_in) state_d = RECV;
         RECV:    state_d = RECV;
         DONE:    state_d = frame_start_in ? RECV : IDLE;
         default: state_d = IDLE;
      endcase
      if (accept && last_byte) begin
         state_d = DONE;
      end
   end

   generate
      for (genvar i = 0; i < LAYER_NUM; i++) begin : g_wr_en
         assign wr_en_d[i] = accept && (layer_cnt == 4'(i));
      end
   endgenerate

   // Output register inputs. Address and data hold between strobes; only the
   // enables are forced low when nothing is written.
   always_comb begin
      wr_addr_d    = accept ? led_cnt : wr_addr_q;
      wr_data_d    = accept ? data_in : wr_data_q;
      wr_byte_en_d = accept ? lane_onehot(byte_cnt, BYTES_PER_LED) : 4'd0;
      // DONE is entered together with the final strobe, so deriving the pulse
      // from the current state puts it one cycle after that strobe.
      wr_done_d    = {LAYER_NUM{state_q == DONE}};
      busy_d       = (state_d == RECV);

      drop_d = drop_q;
      if (frame_start_in) begin
         drop_d = 1'b0;
      end else if (data_vld_in && (state_q != RECV)) begin
         drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         wr_en_q      <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= 8'd0;
         wr_byte_en_q <= 4'd0;
         wr_done_q    <= '0;
         busy_q       <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         wr_byte_en_q <= wr_byte_en_d;
         wr_done_q    <= wr_done_d;
         busy_q       <= busy_d;
         drop_q       <= drop_d;
      end
   end

   assign wr_en_out      = wr_en_q;
   assign wr_addr_out    = wr_addr_q;
   assign wr_data_out    = wr_data_q;
   assign wr_byte_en_out = wr_byte_en_q;
   assign wr_done_out    = wr_done_q;
   assign busy_out       = busy_q;
   assign drop_out       = drop_q;

endmodule
`default_nettype wire

// File: doc/layer_dispatch.md
Name: layer_dispatch

Overview:
- Frame-level write scheduler sitting between the host byte-stream receiver and LAYER_NUM parallel layer_code instances (one per cube layer).
- Demultiplexes an incoming pixel byte stream into per-layer RAM write strobes: layer select, word address, byte lane and data.
- When a full frame is stored, pulses wr_done to all layers in the same cycle, so every layer starts its refresh together.
- Aborts and restarts cleanly on a new frame start.

Parameters:
- LAYER_NUM, 8, number of layer_code instances driven (1..16).
- LED_NUM, 64, LEDs per layer; one RAM word per LED (fixed ≤64, 6-bit address).
- BYTES_PER_LED, 3, colour bytes per LED (1..4).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous reset, active-high
- frame_start_in  in  1  one-cycle pulse: start of a new frame
- data_vld_in  in  1  data_in valid this cycle
- data_in  in  8  pixel byte
- wr_en_out  out  LAYER_NUM  one-hot write strobe per layer
- wr_addr_out  out  6  word address (LED index)
- wr_data_out  out  8  byte to write
- wr_byte_en_out  out  4  one-hot byte lane
- wr_done_out  out  LAYER_NUM  frame-complete pulse, all bits together
- busy_out  out  1  high while in RECV
- drop_out  out  1  sticky: byte arrived outside RECV; cleared by frame_start_in

Behaviour:
- Reset: every output is 0; state IDLE; all counters 0.
  - Asynchronous assert; synchronous deassert is provided externally.
- Counters: byte_cnt (0..BYTES_PER_LED-1), led_cnt (0..LED_NUM-1), layer_cnt (0..LAYER_NUM-1).
  - Stream order is byte-fastest, then LED, then layer.
- States: IDLE, RECV, DONE.
  - IDLE: frame_start_in → RECV, all counters cleared, drop_out cleared.
  - RECV: each data_vld_in byte is accepted; counters advance.
    - On acceptance of the last byte (layer LAYER_NUM-1, LED LED_NUM-1, byte BYTES_PER_LED-1) → DONE.
  - DONE: lasts exactly one cycle; wr_done_out = all ones for that cycle; then → IDLE.
- Write latency: 1 cycle. For a byte accepted in cycle N, cycle N+1 shows:
  - wr_en_out[layer_cnt] = 1, all other bits 0;
  - wr_addr_out = led_cnt;
  - wr_data_out = data_in;
  - wr_byte_en_out = 1 << (BYTES_PER_LED-1-byte_cnt), i.e. the first byte goes to the highest used lane.
  - In all other cycles, wr_en_out and wr_byte_en_out are 0.
- wr_done_out timing: asserted the cycle after the final write strobe; never overlaps any wr_en_out.
- Back-to-back bytes are accepted at 1 per cycle with no stall; there is no ready signal.
- frame_start_in in RECV (abort):
  - counters cleared, state stays RECV, no wr_done_out;
  - partially written RAM contents are left as-is;
  - a write already registered from the previous cycle still completes.
- frame_start_in in DONE: the wr_done pulse still issues; next state is RECV with counters cleared.
- frame_start_in and data_vld_in in the same cycle (any state): the byte is accepted as byte 0 / LED 0 / layer 0 of the new frame.
- data_vld_in in IDLE or DONE (without frame_start_in): byte ignored, drop_out set to 1.
- Counter wrap: byte_cnt wraps to 0 and increments led_cnt; led_cnt wraps to 0 and increments layer_cnt. No other wrap exists; the end of the frame forces DONE.
- busy_out = (state == RECV), registered.

Decomposition:
- Shared package layer_pkg holds:
  - state enum dispatch_state_t {IDLE, RECV, DONE};
  - constant LAYER_ADDR_W = 6;
  - function lane_onehot(byte_idx, bytes_per_led) returning the 4-bit lane mask.
- Natural sub-module: dispatch_cnt, the cascaded byte/LED/layer counter.
  - Inputs: inc, clr.
  - Outputs: the three counts and a last-byte flag.
- The FSM and output registers stay in layer_dispatch.

Test Plan:
- Reset then idle: rst_in=1 mid-RECV → all outputs 0 the same cycle; busy_out=0 after release.
- Full frame, defaults (1536 bytes, data = index mod 256):
  - byte 0 → wr_en_out=8'h01, addr 0, byte_en 4'b0100, data 8'h00;
  - byte 3 → addr 1, byte_en 4'b0100;
  - byte 192 → wr_en_out=8'h02, addr 0;
  - wr_done_out=8'hFF exactly once, the cycle after the last strobe.
- Abort: frame_start_in after 100 bytes, then 1536 bytes → the next write is layer 0 / addr 0 / lane 4'b0100; no wr_done before the full 1536.
- Simultaneous: frame_start_in and data_vld_in (data 8'hA5) → next cycle wr_en_out=8'h01, addr 0, data 8'hA5.
- Drop: 5 bytes in IDLE → no wr_en_out, drop_out=1; frame_start_in → drop_out=0.
- Param variant: BYTES_PER_LED=4, LAYER_NUM=2 → lanes in order 1000, 0100, 0010, 0001; wr_done_out=2'b11 after 512 bytes.
